// File: rtl/mcu_spi_pkg.sv
// ---------------------------------------------------------------------------
// mcu_spi_pkg
// Shared constants and types for the MCU SPI slave front-end.
//   SPI_SYNC_STAGES_DEFAULT : default synchroniser depth (minimum 2)
//   SPI_BYTE_CNT_W          : width of the per-transaction byte counter
//   SPI_BIT_CNT_W           : width of the in-byte bit counter
//   SPI_CNT_MAX             : saturation value of the byte counter
// ---------------------------------------------------------------------------
package mcu_spi_pkg;

    localparam int SPI_SYNC_STAGES_DEFAULT = 2;
    localparam int SPI_BYTE_CNT_W          = 32;
    localparam int SPI_BIT_CNT_W           = 3;

    typedef logic [7:0]                spi_byte_t;
    typedef logic [SPI_BYTE_CNT_W-1:0] spi_byte_cnt_t;
    typedef logic [SPI_BIT_CNT_W-1:0]  spi_bit_cnt_t;

    localparam spi_byte_cnt_t SPI_CNT_MAX = '1;

    // Saturating increment: a very long transaction parks at the maximum
    // instead of wrapping back to 0 and re-triggering command decode.
    function automatic spi_byte_cnt_t spi_sat_inc(input spi_byte_cnt_t cnt);
        return (cnt == SPI_CNT_MAX) ? cnt : cnt + spi_byte_cnt_t'(1);
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// ---------------------------------------------------------------------------
// spi_edge_sync
// Brings an asynchronous pin into the clk domain through STAGES flops, then
// compares the last stage against one history flop to produce single-cycle
// rise/fall flags.
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   i_async  : asynchronous input pin
//   o_rise   : one-cycle flag, synchronised input went 0 -> 1
//   o_fall   : one-cycle flag, synchronised input went 1 -> 0
// STAGES must be at least 2.
// ---------------------------------------------------------------------------
module spi_edge_sync
    import mcu_spi_pkg::*;
#(
    parameter int STAGES = SPI_SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_hist;

    // NOTE: sequential state uses non-blocking assignments so every flop in
    // the chain samples the value from before this edge; blocking here would
    // collapse the synchroniser into a single stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_hist <= r_sync[STAGES-1];
        end
    end

    assign o_rise =  r_sync[STAGES-1] & ~r_hist;
    assign o_fall = ~r_sync[STAGES-1] &  r_hist;

endmodule

// File: rtl/mcu_spi_slave.sv
// ---------------------------------------------------------------------------
// mcu_spi_slave
// SPI mode-0 slave front-end for the command decoder. Oversamples the SPI
// pins in the clk domain, assembles MSB-first bytes, reports the first byte
// of a transaction as a command and later bytes as parameters, and shifts
// the decoder's return byte out on MISO.
//   clk, rst          : system clock (>= 8x SCK), async active-high reset
//   spi_sck           : SPI clock pin (asynchronous)
//   spi_ssel_n        : slave select pin, active low (asynchronous)
//   spi_mosi          : master-out data pin (asynchronous)
//   spi_miso          : slave-out data
//   spi_miso_oe       : MISO drive enable, high while selected
//   spi_data_out      : return byte from the command decoder
//   cmd_ready         : 1-cycle strobe, cmd_data holds a new command byte
//   param_ready       : 1-cycle strobe, param_data holds a new parameter byte
//   cmd_data          : last command byte
//   param_data        : last parameter byte
//   spi_byte_cnt      : bytes completed in the current transaction
//   spi_bit_cnt       : bits received in the current byte
// ---------------------------------------------------------------------------
module mcu_spi_slave
    import mcu_spi_pkg::*;
#(
    parameter int SYNC_STAGES = SPI_SYNC_STAGES_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      spi_sck,
    input  logic                      spi_ssel_n,
    input  logic                      spi_mosi,
    output logic                      spi_miso,
    output logic                      spi_miso_oe,
    input  logic [7:0]                spi_data_out,
    output logic                      cmd_ready,
    output logic                      param_ready,
    output logic [7:0]                cmd_data,
    output logic [7:0]                param_data,
    output logic [SPI_BYTE_CNT_W-1:0] spi_byte_cnt,
    output logic [SPI_BIT_CNT_W-1:0]  spi_bit_cnt
);

    logic w_sck_rise;
    logic w_sck_fall;
    logic w_ssel_rise;   // deassertion
    logic w_ssel_fall;   // assertion

    spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sck_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (spi_sck),
        .o_rise  (w_sck_rise),
        .o_fall  (w_sck_fall)
    );

    spi_edge_sync #(.STAGES(SYNC_STAGES)) u_ssel_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (spi_ssel_n),
        .o_rise  (w_ssel_rise),
        .o_fall  (w_ssel_fall)
    );

    // MOSI gets the same depth as SCK so its last stage holds the bit that
    // was on the pin when the SCK rise reached the edge detector.
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   w_mosi;

    spi_byte_t     r_rx;
    spi_byte_t     r_tx;
    logic          r_tx_reload;
    logic          r_active;      // set by an SSEL assertion edge only
    logic          r_miso;
    logic          r_cmd_ready;
    logic          r_param_ready;
    spi_byte_t     r_cmd_data;
    spi_byte_t     r_param_data;
    spi_byte_cnt_t r_byte_cnt;
    spi_bit_cnt_t  r_bit_cnt;

    spi_byte_t     w_rx_next;
    spi_byte_t     w_tx_next;

    assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
    assign w_rx_next = {r_rx[6:0], w_mosi};
    assign w_tx_next = r_tx_reload ? spi_data_out : {r_tx[6:0], 1'b0};

    // NOTE: the shift registers and data holding registers are reset along
    // with the control state, so nothing from an aborted transaction can be
    // reported or shifted out after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mosi_sync   <= '0;
            r_rx          <= '0;
            r_tx          <= '0;
            r_tx_reload   <= 1'b0;
            r_active      <= 1'b0;
            r_miso        <= 1'b0;
            r_cmd_ready   <= 1'b0;
            r_param_ready <= 1'b0;
            r_cmd_data    <= '0;
            r_param_data  <= '0;
            r_byte_cnt    <= '0;
            r_bit_cnt     <= '0;
        end else begin
            r_mosi_sync   <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_cmd_ready   <= 1'b0;
            r_param_ready <= 1'b0;

            if (w_ssel_fall) begin
                // Assertion: any SCK edge in this cycle is ignored.
                r_active    <= 1'b1;
                r_tx        <= '0;
                r_tx_reload <= 1'b0;
                r_miso      <= 1'b0;
                r_rx        <= '0;
                r_bit_cnt   <= '0;
                r_byte_cnt  <= '0;
            end else if (w_ssel_rise || !r_active) begin
                // Deselected (or never selected since reset): hold idle and
                // drop any partial byte; a coincident SCK edge is ignored.
                r_active    <= 1'b0;
                r_tx_reload <= 1'b0;
                r_miso      <= 1'b0;
                r_rx        <= '0;
                r_bit_cnt   <= '0;
                r_byte_cnt  <= '0;
            end else if (w_sck_rise) begin
                r_rx      <= w_rx_next;
                r_bit_cnt <= r_bit_cnt + spi_bit_cnt_t'(1);
                if (r_bit_cnt == spi_bit_cnt_t'(7)) begin
                    r_byte_cnt  <= spi_sat_inc(r_byte_cnt);
                    r_tx_reload <= 1'b1;
                    if (r_byte_cnt == '0) begin
                        r_cmd_data  <= w_rx_next;
                        r_cmd_ready <= 1'b1;
                    end else begin
                        r_param_data  <= w_rx_next;
                        r_param_ready <= 1'b1;
                    end
                end
            end else if (w_sck_fall) begin
                r_tx        <= w_tx_next;
                r_tx_reload <= 1'b0;
                r_miso      <= w_tx_next[7];
            end
        end
    end

    assign spi_miso     = r_miso;
    assign spi_miso_oe  = r_active;
    assign cmd_ready    = r_cmd_ready;
    assign param_ready  = r_param_ready;
    assign cmd_data     = r_cmd_data;
    assign param_data   = r_param_data;
    assign spi_byte_cnt = r_byte_cnt;
    assign spi_bit_cnt  = r_bit_cnt;

endmodule

// File: tb/tb_mcu_spi_slave.sv
// ---------------------------------------------------------------------------
// tb_mcu_spi_slave
// Directed bench for mcu_spi_slave: an SPI master driven on clk negedges, a
// strobe logger with a tiny decoder model, and hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_mcu_spi_slave;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        spi_sck = 1'b0;
    logic        spi_ssel_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic [7:0]  spi_data_out = 8'h00;
    logic        cmd_ready;
    logic        param_ready;
    logic [7:0]  cmd_data;
    logic [7:0]  param_data;
    logic [31:0] spi_byte_cnt;
    logic [2:0]  spi_bit_cnt;

    mcu_spi_slave #(.SYNC_STAGES(SYNC)) dut (
        .clk          (clk),
        .rst          (rst),
        .spi_sck      (spi_sck),
        .spi_ssel_n   (spi_ssel_n),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .spi_miso_oe  (spi_miso_oe),
        .spi_data_out (spi_data_out),
        .cmd_ready    (cmd_ready),
        .param_ready  (param_ready),
        .cmd_data     (cmd_data),
        .param_data   (param_data),
        .spi_byte_cnt (spi_byte_cnt),
        .spi_bit_cnt  (spi_bit_cnt)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int half    = 8;    // SCK half period in clk cycles
    int dual_cnt = 0;

    typedef struct {
        bit          is_cmd;
        logic [7:0]  data;
        logic [31:0] cnt;
    } strobe_t;

    strobe_t log_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Strobe logger and decoder model: answers a command with 0xA5 and a
    // parameter with 0x3C.
    always @(negedge clk) begin
        if (cmd_ready && param_ready) dual_cnt++;
        if (cmd_ready) begin
            log_q.push_back('{1'b1, cmd_data, spi_byte_cnt});
            spi_data_out = 8'hA5;
        end else if (param_ready) begin
            log_q.push_back('{1'b0, param_data, spi_byte_cnt});
            spi_data_out = 8'h3C;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Master: sets MOSI after SCK falls, samples MISO just before SCK rises.
    task automatic spi_send(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx[7-i];
            wait_clk(half);
            rx = {rx[6:0], spi_miso};
            spi_sck = 1'b1;
            wait_clk(half);
            spi_sck = 1'b0;
        end
    endtask

    task automatic expect_strobe(input string tag, input int idx, input bit is_cmd,
                                 input logic [7:0] data, input logic [31:0] cnt);
        if (idx < log_q.size()) begin
            check({tag, "_kind"}, 32'(log_q[idx].is_cmd), 32'(is_cmd));
            check({tag, "_data"}, 32'(log_q[idx].data), 32'(data));
            check({tag, "_cnt"}, log_q[idx].cnt, cnt);
        end else begin
            check({tag, "_present"}, 32'(log_q.size()), 32'(idx + 1));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cmd_ready"},   32'(cmd_ready),   32'h0);
        check({tag, "_param_ready"}, 32'(param_ready), 32'h0);
        check({tag, "_cmd_data"},    32'(cmd_data),    32'h0);
        check({tag, "_param_data"},  32'(param_data),  32'h0);
        check({tag, "_byte_cnt"},    spi_byte_cnt,     32'h0);
        check({tag, "_bit_cnt"},     32'(spi_bit_cnt), 32'h0);
        check({tag, "_miso"},        32'(spi_miso),    32'h0);
        check({tag, "_miso_oe"},     32'(spi_miso_oe), 32'h0);
    endtask

    logic [7:0] rx;
    logic [7:0] burst [16];

    initial begin
        // Reset values
        #1 rst = 1'b1;
        wait_clk(3);
        check_all_zero("reset");
        rst = 1'b0;
        wait_clk(4);

        // Command 0x81 then parameters 0x12, 0x34, with MISO readback
        log_q.delete();
        spi_ssel_n = 1'b0;
        wait_clk(6);
        check("sel_miso_oe", 32'(spi_miso_oe), 32'h1);
        spi_send(8'h81, 8, rx);
        check("miso_byte0", 32'(rx), 32'h00);
        spi_send(8'h12, 8, rx);
        check("miso_byte1", 32'(rx), 32'hA5);
        spi_send(8'h34, 8, rx);
        check("miso_byte2", 32'(rx), 32'h3C);
        wait_clk(4);
        check("t1_log_size", 32'(log_q.size()), 32'd3);
        expect_strobe("t1_cmd", 0, 1'b1, 8'h81, 32'd1);
        expect_strobe("t1_p1", 1, 1'b0, 8'h12, 32'd2);
        expect_strobe("t1_p2", 2, 1'b0, 8'h34, 32'd3);
        check("t1_byte_cnt", spi_byte_cnt, 32'd3);
        check("t1_bit_cnt", 32'(spi_bit_cnt), 32'd0);
        spi_ssel_n = 1'b1;
        wait_clk(SYNC + 2);
        check("t1_desel_byte_cnt", spi_byte_cnt, 32'd0);
        check("t1_desel_oe", 32'(spi_miso_oe), 32'h0);
        check("t1_cmd_held", 32'(cmd_data), 32'h81);
        check("t1_param_held", 32'(param_data), 32'h34);

        // Deselect after 5 bits of byte 1: partial byte dropped
        wait_clk(4);
        log_q.delete();
        spi_ssel_n = 1'b0;
        wait_clk(6);
        spi_send(8'h55, 8, rx);
        spi_send(8'hFF, 5, rx);
        wait_clk(4);
        check("t2_bit_cnt_mid", 32'(spi_bit_cnt), 32'd5);
        check("t2_byte_cnt_mid", spi_byte_cnt, 32'd1);
        spi_ssel_n = 1'b1;
        wait_clk(SYNC + 2);
        check("t2_abort_bit_cnt", 32'(spi_bit_cnt), 32'd0);
        check("t2_abort_byte_cnt", spi_byte_cnt, 32'd0);
        check("t2_log_size", 32'(log_q.size()), 32'd1);
        expect_strobe("t2_cmd", 0, 1'b1, 8'h55, 32'd1);
        wait_clk(4);
        log_q.delete();
        spi_ssel_n = 1'b0;
        wait_clk(6);
        spi_send(8'h42, 8, rx);
        wait_clk(4);
        check("t2_next_log_size", 32'(log_q.size()), 32'd1);
        expect_strobe("t2_next_cmd", 0, 1'b1, 8'h42, 32'd1);
        spi_ssel_n = 1'b1;
        wait_clk(6);

        // Asynchronous reset in the middle of byte 2
        spi_ssel_n = 1'b0;
        wait_clk(6);
        spi_send(8'h77, 8, rx);
        spi_send(8'h88, 8, rx);
        spi_send(8'hC0, 3, rx);
        @(negedge clk);
        #3 rst = 1'b1;
        #1 check_all_zero("async_rst");
        wait_clk(2);
        rst = 1'b0;
        log_q.delete();
        wait_clk(6);
        check("t3_no_resume_oe", 32'(spi_miso_oe), 32'h0);
        spi_send(8'h99, 8, rx);
        wait_clk(4);
        check("t3_no_resume_log", 32'(log_q.size()), 32'd0);
        check("t3_no_resume_cnt", spi_byte_cnt, 32'd0);
        spi_ssel_n = 1'b1;
        wait_clk(6);
        spi_ssel_n = 1'b0;
        wait_clk(6);
        spi_send(8'hF0, 8, rx);
        wait_clk(4);
        check("t3_log_size", 32'(log_q.size()), 32'd1);
        expect_strobe("t3_cmd", 0, 1'b1, 8'hF0, 32'd1);
        spi_ssel_n = 1'b1;
        wait_clk(6);

        // SSEL deassert coincides with the 8th SCK rise
        log_q.delete();
        spi_ssel_n = 1'b0;
        wait_clk(6);
        spi_send(8'hC3, 7, rx);
        spi_mosi = 1'b1;
        wait_clk(half);
        spi_sck = 1'b1;
        spi_ssel_n = 1'b1;
        wait_clk(half);
        spi_sck = 1'b0;
        wait_clk(6);
        check("t4_log_size", 32'(log_q.size()), 32'd0);
        check("t4_byte_cnt", spi_byte_cnt, 32'd0);
        check("t4_bit_cnt", 32'(spi_bit_cnt), 32'd0);
        check("t4_cmd_held", 32'(cmd_data), 32'hF0);

        // 16-byte burst at clk = 8x SCK
        half = 4;
        log_q.delete();
        spi_ssel_n = 1'b0;
        wait_clk(6);
        for (int i = 0; i < 16; i++) begin
            burst[i] = 8'((i * 37 + 5) & 8'hFF);
            spi_send(burst[i], 8, rx);
        end
        wait_clk(4);
        check("t5_byte_cnt", spi_byte_cnt, 32'd16);
        check("t5_log_size", 32'(log_q.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            expect_strobe($sformatf("t5_b%0d", i), i, (i == 0), burst[i], 32'(i + 1));
        end
        spi_ssel_n = 1'b1;
        wait_clk(6);
        check("t5_end_byte_cnt", spi_byte_cnt, 32'd0);

        check("no_dual_strobe", 32'(dual_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
